// File: rtl/udp_rx_parser_100g.sv
// UDP/IPv4 receive parser for a 512-bit CMAC stream: filters frames addressed to
// this station, strips the 42-byte Ethernet/IPv4/UDP header and realigns the payload.
module udp_rx_parser_100g #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  rx_axis_aclk,
  input  logic                  rx_axis_areset,
  input  logic [DATA_WIDTH-1:0] cmac_rx_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] cmac_rx_axis_tkeep,
  input  logic                  cmac_rx_axis_tvalid,
  input  logic                  cmac_rx_axis_tlast,
  output logic                  cmac_rx_axis_tready,
  input  logic [47:0]           local_mac_addr,
  input  logic [31:0]           local_ip_addr,
  output logic [DATA_WIDTH-1:0] udp_rx_axis_tdata,
  output logic [KEEP_WIDTH-1:0] udp_rx_axis_tkeep,
  output logic                  udp_rx_axis_tvalid,
  output logic                  udp_rx_axis_tlast,
  input  logic                  udp_rx_axis_tready,
  output logic [31:0]           udp_rx_src_ip,
  output logic [15:0]           udp_rx_src_port,
  output logic [15:0]           udp_rx_dst_port,
  output logic [15:0]           udp_rx_length,
  output logic [31:0]           rx_pkt_count,
  output logic [31:0]           rx_drop_count,
  output logic [31:0]           rx_trunc_count
);
  localparam int unsigned HDR_BYTES   = 42;
  localparam int unsigned CARRY_BYTES = KEEP_WIDTH - HDR_BYTES;
  localparam int unsigned SPLIT_W     = HDR_BYTES * 8;
  localparam int unsigned CARRY_W     = CARRY_BYTES * 8;

  typedef enum logic [1:0] {HDR, PASS, FLUSH, DROP} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [KEEP_WIDTH-1:0] out_keep_q, out_keep_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [CARRY_W-1:0]    carry_q, carry_d;
  logic [15:0]           rem_q, rem_d;
  logic [31:0]           src_ip_q, src_ip_d;
  logic [15:0]           src_port_q, src_port_d;
  logic [15:0]           dst_port_q, dst_port_d;
  logic [15:0]           length_q, length_d;
  logic [31:0]           pkt_cnt_q, pkt_cnt_d;
  logic [31:0]           drop_cnt_q, drop_cnt_d;
  logic [31:0]           trunc_cnt_q, trunc_cnt_d;

  logic [47:0] hdr_dst_mac_c;
  logic [15:0] hdr_ethertype_c;
  logic [31:0] hdr_src_ip_c;
  logic [31:0] hdr_dst_ip_c;
  logic [15:0] hdr_src_port_c;
  logic [15:0] hdr_dst_port_c;
  logic [15:0] hdr_udp_len_c;
  logic [15:0] pay_len_c;
  logic        hdr_ok_c;
  logic        out_free_c;
  logic        in_fire_c;
  logic        unused_keep_c;

  // Header fields are big-endian: the most significant byte sits at the lowest byte index.
  assign hdr_dst_mac_c   = {cmac_rx_axis_tdata[7:0],     cmac_rx_axis_tdata[15:8],
                            cmac_rx_axis_tdata[23:16],   cmac_rx_axis_tdata[31:24],
                            cmac_rx_axis_tdata[39:32],   cmac_rx_axis_tdata[47:40]};
  assign hdr_ethertype_c = {cmac_rx_axis_tdata[103:96],  cmac_rx_axis_tdata[111:104]};
  assign hdr_src_ip_c    = {cmac_rx_axis_tdata[215:208], cmac_rx_axis_tdata[223:216],
                            cmac_rx_axis_tdata[231:224], cmac_rx_axis_tdata[239:232]};
  assign hdr_dst_ip_c    = {cmac_rx_axis_tdata[247:240], cmac_rx_axis_tdata[255:248],
                            cmac_rx_axis_tdata[263:256], cmac_rx_axis_tdata[271:264]};
  assign hdr_src_port_c  = {cmac_rx_axis_tdata[279:272], cmac_rx_axis_tdata[287:280]};
  assign hdr_dst_port_c  = {cmac_rx_axis_tdata[295:288], cmac_rx_axis_tdata[303:296]};
  assign hdr_udp_len_c   = {cmac_rx_axis_tdata[311:304], cmac_rx_axis_tdata[319:312]};
  assign pay_len_c       = hdr_udp_len_c - 16'd8;

  assign hdr_ok_c = ((hdr_dst_mac_c == local_mac_addr) || (hdr_dst_mac_c == '1)) &&
                    (hdr_ethertype_c == 16'h0800) &&
                    (cmac_rx_axis_tdata[119:112] == 8'h45) &&
                    (cmac_rx_axis_tdata[191:184] == 8'h11) &&
                    (hdr_dst_ip_c == local_ip_addr) &&
                    (hdr_udp_len_c > 16'd8) &&
                    cmac_rx_axis_tkeep[HDR_BYTES-1];

  assign unused_keep_c = ^cmac_rx_axis_tkeep[KEEP_WIDTH-1:HDR_BYTES+1];

  // Input stalls only on a full output slot or while the carry is being flushed.
  assign cmac_rx_axis_tready = !rx_axis_areset &&
                               ((state_q == DROP) ||
                                ((state_q != FLUSH) && (!out_valid_q || udp_rx_axis_tready)));
  assign out_free_c = !out_valid_q || udp_rx_axis_tready;
  assign in_fire_c  = cmac_rx_axis_tvalid && cmac_rx_axis_tready;

  function automatic logic [KEEP_WIDTH-1:0] keep_mask(input logic [15:0] n);
    if (n >= 16'(KEEP_WIDTH)) return '1;
    return (KEEP_WIDTH'(1) << n) - KEEP_WIDTH'(1);
  endfunction

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_valid_d = out_free_c ? 1'b0 : out_valid_q;
    carry_d     = carry_q;
    rem_d       = rem_q;
    src_ip_d    = src_ip_q;
    src_port_d  = src_port_q;
    dst_port_d  = dst_port_q;
    length_d    = length_q;
    pkt_cnt_d   = pkt_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    trunc_cnt_d = trunc_cnt_q;

    case (state_q)
      HDR: begin
        if (in_fire_c && !hdr_ok_c) begin
          drop_cnt_d = drop_cnt_q + 32'd1;
          state_d    = cmac_rx_axis_tlast ? HDR : DROP;
        end else if (in_fire_c) begin
          src_ip_d   = hdr_src_ip_c;
          src_port_d = hdr_src_port_c;
          dst_port_d = hdr_dst_port_c;
          length_d   = pay_len_c;
          pkt_cnt_d  = pkt_cnt_q + 32'd1;
          carry_d    = cmac_rx_axis_tdata[DATA_WIDTH-1:SPLIT_W];
          rem_d      = pay_len_c;
          if (pay_len_c <= 16'(CARRY_BYTES)) begin
            out_data_d  = cmac_rx_axis_tdata >> SPLIT_W;
            out_keep_d  = keep_mask(pay_len_c);
            out_last_d  = 1'b1;
            out_valid_d = 1'b1;
            state_d     = cmac_rx_axis_tlast ? HDR : DROP;
          end else if (cmac_rx_axis_tlast) begin
            trunc_cnt_d = trunc_cnt_q + 32'd1;
            state_d     = cmac_rx_axis_tkeep[HDR_BYTES] ? FLUSH : HDR;
          end else begin
            state_d = PASS;
          end
        end
      end
      PASS: begin
        if (in_fire_c) begin
          // Previous beat's tail first, then the head of this beat.
          out_data_d  = {cmac_rx_axis_tdata[SPLIT_W-1:0], carry_q};
          out_valid_d = 1'b1;
          carry_d     = cmac_rx_axis_tdata[DATA_WIDTH-1:SPLIT_W];
          if (rem_q <= 16'(KEEP_WIDTH)) begin
            out_keep_d = keep_mask(rem_q);
            out_last_d = 1'b1;
            rem_d      = '0;
            state_d    = cmac_rx_axis_tlast ? HDR : DROP;
          end else if (cmac_rx_axis_tlast && cmac_rx_axis_tkeep[HDR_BYTES]) begin
            trunc_cnt_d = trunc_cnt_q + 32'd1;
            out_keep_d  = '1;
            out_last_d  = 1'b0;
            rem_d       = rem_q - 16'(KEEP_WIDTH);
            state_d     = FLUSH;
          end else if (cmac_rx_axis_tlast) begin
            trunc_cnt_d = trunc_cnt_q + 32'd1;
            out_keep_d  = {cmac_rx_axis_tkeep[HDR_BYTES-1:0], {CARRY_BYTES{1'b1}}};
            out_last_d  = 1'b1;
            state_d     = HDR;
          end else begin
            out_keep_d = '1;
            out_last_d = 1'b0;
            rem_d      = rem_q - 16'(KEEP_WIDTH);
          end
        end
      end
      FLUSH: begin
        if (out_free_c) begin
          out_data_d  = DATA_WIDTH'(carry_q);
          out_keep_d  = keep_mask((rem_q < 16'(CARRY_BYTES)) ? rem_q : 16'(CARRY_BYTES));
          out_last_d  = 1'b1;
          out_valid_d = 1'b1;
          state_d     = HDR;
        end
      end
      DROP: begin
        if (in_fire_c && cmac_rx_axis_tlast) state_d = HDR;
      end
      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge rx_axis_aclk or posedge rx_axis_areset) begin
    if (rx_axis_areset) begin
      state_q     <= HDR;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      carry_q     <= '0;
      rem_q       <= '0;
      src_ip_q    <= '0;
      src_port_q  <= '0;
      dst_port_q  <= '0;
      length_q    <= '0;
      pkt_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      trunc_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      carry_q     <= carry_d;
      rem_q       <= rem_d;
      src_ip_q    <= src_ip_d;
      src_port_q  <= src_port_d;
      dst_port_q  <= dst_port_d;
      length_q    <= length_d;
      pkt_cnt_q   <= pkt_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      trunc_cnt_q <= trunc_cnt_d;
    end
  end

  assign udp_rx_axis_tdata  = out_data_q;
  assign udp_rx_axis_tkeep  = out_keep_q;
  assign udp_rx_axis_tvalid = out_valid_q;
  assign udp_rx_axis_tlast  = out_last_q;
  assign udp_rx_src_ip      = src_ip_q;
  assign udp_rx_src_port    = src_port_q;
  assign udp_rx_dst_port    = dst_port_q;
  assign udp_rx_length      = length_q;
  assign rx_pkt_count       = pkt_cnt_q;
  assign rx_drop_count      = drop_cnt_q;
  assign rx_trunc_count     = trunc_cnt_q;

endmodule

// File: doc/udp_rx_parser_100g.md
UDP_RX_PARSER_100G -- requirements
Module: udp_rx_parser_100g

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, stream width in bits; only 512 is supported.
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, byte-enable width.
REQ-003 SHALL have a single clock domain and an asynchronous active-high reset:
  rx_axis_aclk  in  1  sole clock
  rx_axis_areset  in  1  asynchronous reset, active high
REQ-004 SHALL have these ports (name, direction, width, meaning):
  cmac_rx_axis_tdata  in  512  frame data from CMAC; byte n = bits [8n+7:8n]
  cmac_rx_axis_tkeep  in  64  contiguous byte enables
  cmac_rx_axis_tvalid  in  1  beat valid
  cmac_rx_axis_tlast  in  1  last beat of frame
  cmac_rx_axis_tready  out  1  beat accepted when tvalid&tready
  local_mac_addr  in  48  station MAC, quasi-static
  local_ip_addr  in  32  station IPv4, quasi-static
  udp_rx_axis_tdata  out  512  realigned UDP payload, payload byte 0 = bits [7:0]
  udp_rx_axis_tkeep  out  64  payload byte enables, contiguous from bit 0
  udp_rx_axis_tvalid  out  1  payload beat valid
  udp_rx_axis_tlast  out  1  last payload beat
  udp_rx_axis_tready  in  1  downstream ready
  udp_rx_src_ip  out  32  source IP of current packet
  udp_rx_src_port  out  16  UDP source port
  udp_rx_dst_port  out  16  UDP destination port
  udp_rx_length  out  16  payload length in bytes (UDP length - 8)
  rx_pkt_count  out  32  accepted packets
  rx_drop_count  out  32  dropped frames
  rx_trunc_count  out  32  truncated accepted packets

Function
REQ-005 SHALL parse the header from the first beat; fields big-endian, MSB at lowest byte index: dst MAC 0-5, ethertype 12-13, ver/IHL 14, protocol 23, src IP 26-29, dst IP 30-33, src port 34-35, dst port 36-37, UDP length 38-39.
REQ-006 SHALL accept a frame only if: dst MAC == local_mac_addr or all-ones; ethertype 0x0800; byte 14 == 0x45; protocol 0x11; dst IP == local_ip_addr; UDP length > 8; tkeep[41] set.
REQ-007 SHALL use states HDR, PASS, FLUSH, DROP; reset state HDR.
REQ-008 SHALL, in HDR on a rejected first beat, increment rx_drop_count and go to DROP, or stay in HDR if tlast.
REQ-009 SHALL, on an accepted first beat, latch metadata, set remaining R = UDP length - 8, increment rx_pkt_count, and store bytes 42-63 as carry.
REQ-010 SHALL, if R <= 22 on the first beat, emit one beat: data = first beat shifted down 42 bytes, keep = lowest R bits set, tlast=1; next state HDR if input tlast, else DROP.
REQ-011 SHALL, in PASS, emit out bytes 0-21 = carry and bytes 22-63 = input bytes 0-41; update carry = input bytes 42-63; decrement R by 64.
REQ-012 SHALL, when R <= 64 in PASS, mask keep to R bytes and assert tlast; next state HDR if input tlast, else DROP (discards padding/FCS).
REQ-013 SHALL treat input tlast with R > 64 in PASS as truncation and increment rx_trunc_count: go to FLUSH if input tkeep[42] set, otherwise assert tlast on the current beat and go to HDR.
REQ-014 SHALL, in FLUSH, emit carry bytes in bytes 0-21 with keep = min(R,22) bytes and tlast=1, accept no input, and go to HDR.
REQ-015 SHALL, in DROP, assert cmac_rx_axis_tready=1, emit nothing, and return to HDR on accepted tlast.
REQ-016 SHALL register the output in one stage, giving 1-cycle latency from accepted input beat to udp_rx_axis_tvalid.
REQ-017 SHALL drive cmac_rx_axis_tready = DROP or (state != FLUSH and (!udp_rx_axis_tvalid or udp_rx_axis_tready)).
REQ-018 SHALL hold output data/keep/last stable while tvalid=1 and tready=0.
REQ-019 SHALL hold metadata stable from the first payload beat through the tlast handshake.
REQ-020 SHALL let all counters wrap modulo 2^32 and never saturate.
REQ-021 SHALL never emit a beat with all-zero tkeep.

Reset
REQ-022 SHALL, on rx_axis_areset, immediately force state HDR, all outputs and counters 0, and cmac_rx_axis_tready 0 while reset is asserted.
REQ-023 SHALL, on reset mid-packet, discard the partial packet with no tlast emitted; the next frame is parsed from its first beat.

Verification
REQ-024 SHALL cover: matching frame, UDP len 30 (22 B payload), single beat with tlast -> one output beat, keep=0x3FFFFF, tlast=1, rx_pkt_count=1.
REQ-025 SHALL cover: matching 2-beat frame, UDP len 72 (64 B payload), 106 B frame -> one beat, keep all-ones, tlast; payload bytes 0-63 match input bytes 42-105.
REQ-026 SHALL cover: 60 B frame, UDP len 12 plus padding, tlast on beat 1 -> one beat, keep=0xF, padding discarded.
REQ-027 SHALL cover: wrong dst IP, then protocol 6, then ethertype 0x86DD -> no output, rx_drop_count=3, following valid frame passes.
REQ-028 SHALL cover: backpressure, udp_rx_axis_tready toggling 1/0 on a 4-beat packet -> cmac_rx_axis_tready tracks it, payload unchanged, no beat lost or duplicated.
REQ-029 SHALL cover: UDP len 200 with frame ending at 150 B -> 2 beats, second tlast with 44 bytes enabled, rx_trunc_count=1.
